// File: rtl/regfile_scoreboard.sv
// regfile_scoreboard
// Multi-ported register file with a per-register busy scoreboard for RAW
// hazard detection. Decode claims destination registers; writeback writes
// data and releases them. Reads are combinational with zero latency.
//
// Optional macro: REGFILE_BYPASS_EN
//   defined   - same-cycle writes are forwarded to matching read ports and
//               mask read_busy for those ports.
//   undefined - reads return stored values only; read_busy is unmasked.
module regfile_scoreboard #(
  parameter int  REG_WIDTH       = 32,
  parameter int  NUM_REGS        = 32,
  parameter int  ADDR_WIDTH      = $clog2(NUM_REGS),
  parameter int  NUM_READ_PORTS  = 2,
  parameter int  NUM_WRITE_PORTS = 1,
  parameter bit  REG_ZERO_GROUND = 1'b1,
  localparam int CNT_WIDTH       = $clog2(NUM_REGS + 1)
) (
  input  logic                                  clk,
  input  logic                                  rst_n,
  input  logic [NUM_WRITE_PORTS-1:0]            write_enable,
  input  logic [NUM_WRITE_PORTS*ADDR_WIDTH-1:0] write_addr,
  input  logic [NUM_WRITE_PORTS*REG_WIDTH-1:0]  write_data,
  input  logic [NUM_READ_PORTS*ADDR_WIDTH-1:0]  read_addr,
  output logic [NUM_READ_PORTS*REG_WIDTH-1:0]   read_data,
  output logic [NUM_READ_PORTS-1:0]             read_busy,
  input  logic                                  claim_valid,
  input  logic [ADDR_WIDTH-1:0]                 claim_addr,
  output logic [CNT_WIDTH-1:0]                  busy_count
);

  logic [REG_WIDTH-1:0]       regs [NUM_REGS];
  logic [NUM_REGS-1:0]        busy;

  logic [ADDR_WIDTH-1:0]      wr_addr [NUM_WRITE_PORTS];
  logic [REG_WIDTH-1:0]       wr_data [NUM_WRITE_PORTS];
  logic [NUM_WRITE_PORTS-1:0] wr_en;
  logic                       claim_en;

  logic [NUM_REGS-1:0]        wr_vec;
  logic [NUM_REGS-1:0]        set_vec;
  logic [NUM_REGS-1:0]        clr_vec;
  logic [NUM_REGS-1:0]        busy_next;
  logic                       set_new;
  logic [CNT_WIDTH-1:0]       clr_count;

  // An address is actionable when it exists and is not the grounded zero register.
  function automatic logic addr_ok(input logic [ADDR_WIDTH-1:0] a);
    return (int'(a) < NUM_REGS) && !(REG_ZERO_GROUND && (a == '0));
  endfunction

  // Unpack the flattened write ports; out-of-range and grounded writes are dropped here.
  for (genvar p = 0; p < NUM_WRITE_PORTS; p++) begin : g_wr
    assign wr_addr[p] = write_addr[p*ADDR_WIDTH +: ADDR_WIDTH];
    assign wr_data[p] = write_data[p*REG_WIDTH +: REG_WIDTH];
    assign wr_en[p]   = write_enable[p] && addr_ok(wr_addr[p]);
  end

  assign claim_en = claim_valid && addr_ok(claim_addr);

  // Scoreboard next state: claims override same-cycle writes; the count delta is exact.
  always_comb begin
    // NOTE: every variable gets a default before any conditional write, so no latch is inferred.
    wr_vec    = '0;
    set_vec   = '0;
    clr_count = '0;
    for (int p = 0; p < NUM_WRITE_PORTS; p++) begin
      if (wr_en[p]) wr_vec[wr_addr[p]] = 1'b1;
    end
    if (claim_en) set_vec[claim_addr] = 1'b1;
    clr_vec   = busy & wr_vec & ~set_vec;
    busy_next = (busy & ~clr_vec) | set_vec;
    set_new   = |(set_vec & ~busy);
    for (int i = 0; i < NUM_REGS; i++) begin
      clr_count = clr_count + CNT_WIDTH'(clr_vec[i]);
    end
  end

  // Busy vector and its population count, updated together so they never disagree.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy       <= '0;
      busy_count <= '0;
    end else begin
      busy       <= busy_next;
      busy_count <= busy_count + CNT_WIDTH'(set_new) - clr_count;
    end
  end

  // Register storage; ports are applied in ascending order so the highest index wins.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: storage sits in the async reset domain because reads must return 0 straight after reset.
      for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
    end else begin
      for (int p = 0; p < NUM_WRITE_PORTS; p++) begin
        // NOTE: non-blocking updates to one address resolve to the last one issued, i.e. the highest port.
        if (wr_en[p]) regs[wr_addr[p]] <= wr_data[p];
      end
    end
  end

  // Combinational read ports with optional same-cycle forwarding.
  for (genvar r = 0; r < NUM_READ_PORTS; r++) begin : g_rd
    logic [ADDR_WIDTH-1:0] ra;
    logic [REG_WIDTH-1:0]  rd;
    logic                  rb;

    assign ra = read_addr[r*ADDR_WIDTH +: ADDR_WIDTH];

    // Select stored value and busy flag; grounded or missing registers read as idle zero.
    always_comb begin
      rd = '0;
      rb = 1'b0;
      if (addr_ok(ra)) begin
        rd = regs[ra];
        rb = busy[ra];
`ifdef REGFILE_BYPASS_EN
        for (int p = 0; p < NUM_WRITE_PORTS; p++) begin
          if (wr_en[p] && (wr_addr[p] == ra)) begin
            rd = wr_data[p];
            rb = 1'b0;
          end
        end
`endif
      end
    end

    assign read_data[r*REG_WIDTH +: REG_WIDTH] = rd;
    assign read_busy[r]                        = rb;
  end

endmodule

// File: tb/tb_regfile_scoreboard.sv
// Testbench for regfile_scoreboard: directed vector table, a small
// non-power-of-two instance, randomized traffic against an array-based
// reference model, and asynchronous reset during a claim sequence.
module tb_regfile_scoreboard;

  localparam int RW  = 32;
  localparam int NR  = 32;
  localparam int AW  = 5;
  localparam int NRP = 2;
  localparam int NWP = 2;
  localparam int CW  = 6;
`ifdef REGFILE_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic clk;
  logic rst_n;

  // Main instance stimulus
  logic [NWP-1:0] we;
  logic [AW-1:0]  wa [NWP];
  logic [RW-1:0]  wd [NWP];
  logic [AW-1:0]  ra [NRP];
  logic           cv;
  logic [AW-1:0]  ca;

  logic [NWP*AW-1:0] write_addr;
  logic [NWP*RW-1:0] write_data;
  logic [NRP*AW-1:0] read_addr;
  logic [NRP*RW-1:0] read_data;
  logic [NRP-1:0]    read_busy;
  logic [CW-1:0]     busy_count;
  logic [RW-1:0]     rd [NRP];

  assign write_addr = {wa[1], wa[0]};
  assign write_data = {wd[1], wd[0]};
  assign read_addr  = {ra[1], ra[0]};
  assign rd[0]      = read_data[RW-1:0];
  assign rd[1]      = read_data[2*RW-1:RW];

  // Small non-power-of-two instance (6 registers, 3-bit addresses)
  logic       b_we;
  logic [2:0] b_wa;
  logic [7:0] b_wd;
  logic [2:0] b_ra;
  logic [7:0] b_rd;
  logic       b_rb;
  logic       b_cv;
  logic [2:0] b_ca;
  logic [2:0] b_cnt;

  regfile_scoreboard #(
    .REG_WIDTH(RW), .NUM_REGS(NR), .ADDR_WIDTH(AW),
    .NUM_READ_PORTS(NRP), .NUM_WRITE_PORTS(NWP), .REG_ZERO_GROUND(1'b1)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .write_enable(we), .write_addr(write_addr), .write_data(write_data),
    .read_addr(read_addr), .read_data(read_data), .read_busy(read_busy),
    .claim_valid(cv), .claim_addr(ca), .busy_count(busy_count)
  );

  regfile_scoreboard #(
    .REG_WIDTH(8), .NUM_REGS(6), .ADDR_WIDTH(3),
    .NUM_READ_PORTS(1), .NUM_WRITE_PORTS(1), .REG_ZERO_GROUND(1'b1)
  ) dut_small (
    .clk(clk), .rst_n(rst_n),
    .write_enable(b_we), .write_addr(b_wa), .write_data(b_wd),
    .read_addr(b_ra), .read_data(b_rd), .read_busy(b_rb),
    .claim_valid(b_cv), .claim_addr(b_ca), .busy_count(b_cnt)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual=0x%0h required=0x%0h", name, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  logic [RW-1:0] m_reg [NR];
  logic [NR-1:0] m_busy;

  function automatic void m_reset();
    for (int i = 0; i < NR; i++) m_reg[i] = '0;
    m_busy = '0;
  endfunction

  // Value a read of address a should return given the current inputs.
  function automatic logic [RW-1:0] m_read(input int a);
    logic [RW-1:0] v;
    if (a == 0) return '0;
    v = m_reg[a];
    if (BYP) begin
      for (int p = 0; p < NWP; p++)
        if (we[p] && int'(wa[p]) == a) v = wd[p];
    end
    return v;
  endfunction

  function automatic logic m_rbusy(input int a);
    logic b;
    if (a == 0) return 1'b0;
    b = m_busy[a];
    if (BYP) begin
      for (int p = 0; p < NWP; p++)
        if (we[p] && int'(wa[p]) == a) b = 1'b0;
    end
    return b;
  endfunction

  // Apply one clock edge worth of writes and claims.
  function automatic void m_edge();
    for (int p = 0; p < NWP; p++)
      if (we[p] && wa[p] != 0) m_reg[wa[p]] = wd[p];
    for (int p = 0; p < NWP; p++)
      if (we[p]) m_busy[wa[p]] = 1'b0;
    if (cv && ca != 0) m_busy[ca] = 1'b1;
  endfunction

  task automatic check_all(input string tag);
    for (int p = 0; p < NRP; p++) begin
      check($sformatf("%s rd%0d a=%0d", tag, p, ra[p]), rd[p], m_read(int'(ra[p])));
      check($sformatf("%s rb%0d a=%0d", tag, p, ra[p]), read_busy[p], m_rbusy(int'(ra[p])));
    end
    check($sformatf("%s busy_count", tag), busy_count, $countones(m_busy));
  endtask

  task automatic idle();
    we = '0; cv = 1'b0; ca = '0;
    for (int p = 0; p < NWP; p++) begin wa[p] = '0; wd[p] = '0; end
    for (int p = 0; p < NRP; p++) ra[p] = '0;
    b_we = 1'b0; b_wa = '0; b_wd = '0; b_ra = '0; b_cv = 1'b0; b_ca = '0;
  endtask

  // Advance through one rising edge; inputs stay stable until 1 time unit after it.
  task automatic step();
    @(posedge clk);
    m_edge();
    #1;
  endtask

  function automatic logic [AW-1:0] rnd_addr();
    if ($urandom_range(0, 1) == 0) return AW'($urandom_range(0, 7));
    return AW'($urandom_range(0, NR - 1));
  endfunction

  // ---------------- directed vector table ----------------
  typedef struct {
    logic [1:0]  we;
    logic [4:0]  wa0;
    logic [31:0] wd0;
    logic [4:0]  wa1;
    logic [31:0] wd1;
    logic [4:0]  ra;
    logic        cv;
    logic [4:0]  ca;
    logic [31:0] exp_rd;
    logic        exp_rb;
    logic [5:0]  exp_cnt;
  } vec_t;

  localparam int NVEC = 26;
  vec_t tbl [NVEC];

  initial begin
    //          we     wa0    wd0            wa1    wd1       ra     cv    ca     exp_rd                       exp_rb        cnt
    tbl[0]  = '{2'b01, 5'd0,  32'hDEADBEEF,  5'd0,  32'h0,    5'd0,  1'b0, 5'd0,  32'h0,                       1'b0,         6'd0};
    tbl[1]  = '{2'b00, 5'd0,  32'h0,         5'd0,  32'h0,    5'd0,  1'b0, 5'd0,  32'h0,                       1'b0,         6'd0};
    tbl[2]  = '{2'b00, 5'd0,  32'h0,         5'd0,  32'h0,    5'd5,  1'b1, 5'd5,  32'h0,                       1'b0,         6'd0};
    tbl[3]  = '{2'b00, 5'd0,  32'h0,         5'd0,  32'h0,    5'd5,  1'b0, 5'd0,  32'h0,                       1'b1,         6'd1};
    tbl[4]  = '{2'b01, 5'd5,  32'h1234,      5'd0,  32'h0,    5'd5,  1'b0, 5'd0,  BYP ? 32'h1234 : 32'h0,      BYP ? 1'b0 : 1'b1, 6'd1};
    tbl[5]  = '{2'b00, 5'd0,  32'h0,         5'd0,  32'h0,    5'd5,  1'b0, 5'd0,  32'h1234,                    1'b0,         6'd0};
    tbl[6]  = '{2'b11, 5'd7,  32'hAAAA,      5'd7,  32'h5555, 5'd7,  1'b0, 5'd0,  BYP ? 32'h5555 : 32'h0,      1'b0,         6'd0};
    tbl[7]  = '{2'b00, 5'd0,  32'h0,         5'd0,  32'h0,    5'd7,  1'b0, 5'd0,  32'h5555,                    1'b0,         6'd0};
    tbl[8]  = '{2'b00, 5'd0,  32'h0,         5'd0,  32'h0,    5'd9,  1'b1, 5'd9,  32'h0,                       1'b0,         6'd0};
    tbl[9]  = '{2'b01, 5'd9,  32'h99,        5'd0,  32'h0,    5'd9,  1'b1, 5'd9,  BYP ? 32'h99 : 32'h0,        BYP ? 1'b0 : 1'b1, 6'd1};
    tbl[10] = '{2'b00, 5'd0,  32'h0,         5'd0,  32'h0,    5'd9,  1'b0, 5'd0,  32'h99,                      1'b1,         6'd1};
    tbl[11] = '{2'b00, 5'd0,  32'h0,         5'd0,  32'h0,    5'd4,  1'b1, 5'd4,  32'h0,                       1'b0,         6'd1};
    tbl[12] = '{2'b01, 5'd4,  32'h44,        5'd0,  32'h0,    5'd4,  1'b1, 5'd3,  BYP ? 32'h44 : 32'h0,        BYP ? 1'b0 : 1'b1, 6'd2};
    tbl[13] = '{2'b00, 5'd0,  32'h0,         5'd0,  32'h0,    5'd3,  1'b0, 5'd0,  32'h0,                       1'b1,         6'd2};
    tbl[14] = '{2'b01, 5'd9,  32'h1,         5'd0,  32'h0,    5'd3,  1'b0, 5'd0,  32'h0,                       1'b1,         6'd2};
    tbl[15] = '{2'b00, 5'd0,  32'h0,         5'd0,  32'h0,    5'd9,  1'b0, 5'd0,  32'h1,                       1'b0,         6'd1};
    tbl[16] = '{2'b11, 5'd3,  32'h33,        5'd3,  32'h34,   5'd3,  1'b0, 5'd0,  BYP ? 32'h34 : 32'h0,        BYP ? 1'b0 : 1'b1, 6'd1};
    tbl[17] = '{2'b00, 5'd0,  32'h0,         5'd0,  32'h0,    5'd3,  1'b0, 5'd0,  32'h34,                      1'b0,         6'd0};
    tbl[18] = '{2'b00, 5'd0,  32'h0,         5'd0,  32'h0,    5'd0,  1'b1, 5'd0,  32'h0,                       1'b0,         6'd0};
    tbl[19] = '{2'b00, 5'd0,  32'h0,         5'd0,  32'h0,    5'd0,  1'b0, 5'd0,  32'h0,                       1'b0,         6'd0};
    tbl[20] = '{2'b00, 5'd0,  32'h0,         5'd0,  32'h0,    5'd12, 1'b1, 5'd12, 32'h0,                       1'b0,         6'd0};
    tbl[21] = '{2'b00, 5'd0,  32'h0,         5'd0,  32'h0,    5'd12, 1'b1, 5'd12, 32'h0,                       1'b1,         6'd1};
    tbl[22] = '{2'b00, 5'd0,  32'h0,         5'd0,  32'h0,    5'd12, 1'b0, 5'd0,  32'h0,                       1'b1,         6'd1};
    tbl[23] = '{2'b00, 5'd0,  32'h0,         5'd0,  32'h0,    5'd20, 1'b1, 5'd20, 32'h0,                       1'b0,         6'd1};
    tbl[24] = '{2'b11, 5'd12, 32'hC,         5'd20, 32'h14,   5'd20, 1'b0, 5'd0,  BYP ? 32'h14 : 32'h0,        BYP ? 1'b0 : 1'b1, 6'd2};
    tbl[25] = '{2'b00, 5'd0,  32'h0,         5'd0,  32'h0,    5'd20, 1'b0, 5'd0,  32'h14,                      1'b0,         6'd0};
  end

  // ---------------- main sequence ----------------
  initial begin
    rst_n = 1'b0;
    idle();
    m_reset();

    // Reset state while held in reset
    #8;
    check("in-reset busy_count", busy_count, 0);
    check("in-reset rd0", rd[0], 0);
    check("in-reset rb0", read_busy[0], 0);
    @(negedge clk);
    rst_n = 1'b1;
    step();

    // Every address on every port reads idle zero after reset
    for (int i = 0; i < NR; i++) begin
      ra[0] = AW'(i);
      ra[1] = AW'(NR - 1 - i);
      #1;
      check($sformatf("post-reset rd0 a=%0d", i), rd[0], 0);
      check($sformatf("post-reset rd1 a=%0d", NR - 1 - i), rd[1], 0);
      check($sformatf("post-reset rb0 a=%0d", i), read_busy[0], 0);
      check($sformatf("post-reset rb1 a=%0d", NR - 1 - i), read_busy[1], 0);
    end
    check("post-reset busy_count", busy_count, 0);
    idle();
    step();

    // Directed table
    for (int i = 0; i < NVEC; i++) begin
      we    = tbl[i].we;
      wa[0] = tbl[i].wa0; wd[0] = tbl[i].wd0;
      wa[1] = tbl[i].wa1; wd[1] = tbl[i].wd1;
      ra[0] = tbl[i].ra;  ra[1] = tbl[i].ra;
      cv    = tbl[i].cv;  ca    = tbl[i].ca;
      @(negedge clk);
      check($sformatf("vec%0d rd0", i), rd[0], tbl[i].exp_rd);
      check($sformatf("vec%0d rd1", i), rd[1], tbl[i].exp_rd);
      check($sformatf("vec%0d rb0", i), read_busy[0], tbl[i].exp_rb);
      check($sformatf("vec%0d rb1", i), read_busy[1], tbl[i].exp_rb);
      check($sformatf("vec%0d busy_count", i), busy_count, tbl[i].exp_cnt);
      step();
    end
    idle();

    // Non-power-of-two depth: addresses 6 and 7 do not exist
    b_we = 1'b1; b_wa = 3'd5; b_wd = 8'hA5;
    step();
    b_wa = 3'd6; b_wd = 8'h66;
    step();
    b_we = 1'b0; b_cv = 1'b1; b_ca = 3'd7;
    step();
    b_cv = 1'b0;
    b_ra = 3'd5; #1;
    check("small rd a=5", b_rd, 8'hA5);
    b_ra = 3'd6; #1;
    check("small rd a=6", b_rd, 8'h00);
    check("small rb a=6", b_rb, 1'b0);
    b_ra = 3'd7; #1;
    check("small rd a=7", b_rd, 8'h00);
    check("small rb a=7", b_rb, 1'b0);
    check("small busy_count after bad claim", b_cnt, 3'd0);
    step();
    b_cv = 1'b1; b_ca = 3'd5;
    step();
    b_cv = 1'b0; b_ra = 3'd5; #1;
    check("small rb a=5 claimed", b_rb, 1'b1);
    check("small busy_count claimed", b_cnt, 3'd1);
    b_we = 1'b1; b_wa = 3'd5; b_wd = 8'h5A;
    step();
    b_we = 1'b0; #1;
    check("small busy_count released", b_cnt, 3'd0);
    check("small rd a=5 rewritten", b_rd, 8'h5A);
    idle();
    step();

    // Randomized traffic against the reference model
    for (int n = 0; n < 400; n++) begin
      for (int p = 0; p < NWP; p++) begin
        we[p] = ($urandom_range(0, 2) == 0);
        wa[p] = rnd_addr();
        wd[p] = $urandom;
      end
      for (int p = 0; p < NRP; p++) ra[p] = rnd_addr();
      cv = ($urandom_range(0, 1) == 1);
      ca = rnd_addr();
      @(negedge clk);
      check_all($sformatf("rand%0d", n));
      step();
    end
    idle();

    // Fill the scoreboard completely
    rst_n = 1'b0;
    m_reset();
    #2;
    check("fill pre-reset busy_count", busy_count, 0);
    @(negedge clk);
    rst_n = 1'b1;
    step();
    for (int i = 1; i < NR; i++) begin
      cv    = 1'b1;
      ca    = AW'(i);
      ra[0] = AW'(i);
      ra[1] = AW'(i - 1);
      @(negedge clk);
      check_all($sformatf("fill%0d", i));
      step();
    end
    cv = 1'b1; ca = AW'(17);
    @(negedge clk);
    check("full busy_count", busy_count, NR - 1);
    step();
    cv = 1'b1; ca = '0;
    step();
    cv = 1'b0;
    @(negedge clk);
    check("full busy_count after reclaim", busy_count, NR - 1);
    check_all("full");
    step();

    // Asynchronous reset in the middle of a claim sequence
    rst_n = 1'b0;
    m_reset();
    #2;
    @(negedge clk);
    rst_n = 1'b1;
    step();
    for (int i = 1; i <= 10; i++) begin
      cv    = 1'b1;
      ca    = AW'(i);
      we    = 2'b01;
      wa[0] = AW'(i + 15);
      wd[0] = 32'hC0DE_0000 + 32'(i);
      step();
    end
    ra[0] = AW'(16);
    ra[1] = AW'(5);
    #1;
    check("pre-async-reset rd0 a=16", rd[0], 32'hC0DE_0001);
    check("pre-async-reset rb1 a=5", read_busy[1], 1'b1);
    check("pre-async-reset busy_count", busy_count, 10);
    rst_n = 1'b0;
    m_reset();
    #1;
    check("async-reset busy_count", busy_count, 0);
    check("async-reset rd0 a=16", rd[0], 0);
    check("async-reset rb1 a=5", read_busy[1], 0);
    ra[0] = AW'(3);
    #1;
    check("async-reset rb0 a=3", read_busy[0], 0);
    idle();
    @(negedge clk);
    rst_n = 1'b1;
    step();
    ra[0] = AW'(5);
    ra[1] = AW'(16);
    @(negedge clk);
    check_all("after-reset");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/regfile_scoreboard.md
Name: regfile_scoreboard

Overview:
- Parametrised successor to the decode-stage register controller.
- Provides a multi-ported register file with configurable read/write port counts and write-to-read bypass.
- Adds a per-register busy scoreboard so issue logic can detect pending writebacks (RAW hazards).
- Sits between decode (reads, destination claims) and writeback (writes).

Parameters:
- REG_WIDTH, 32: data width of each register.
- NUM_REGS, 32: number of architectural registers (>=2).
- ADDR_WIDTH, $clog2(NUM_REGS): register address width.
- NUM_READ_PORTS, 2: number of independent combinational read ports (>=1).
- NUM_WRITE_PORTS, 1: number of writeback ports (>=1).
- REG_ZERO_GROUND, 1: when 1, register 0 reads as 0, ignores writes, and is never busy.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- write_enable  input  NUM_WRITE_PORTS  per-port write strobe.
- write_addr  input  NUM_WRITE_PORTS*ADDR_WIDTH  flattened write addresses; port p at [p*ADDR_WIDTH +: ADDR_WIDTH].
- write_data  input  NUM_WRITE_PORTS*REG_WIDTH  flattened write data.
- read_addr  input  NUM_READ_PORTS*ADDR_WIDTH  flattened read addresses.
- read_data  output  NUM_READ_PORTS*REG_WIDTH  flattened read data.
- read_busy  output  NUM_READ_PORTS  1 = addressed register has a pending producer.
- claim_valid  input  1  decode claims a destination register this cycle.
- claim_addr  input  ADDR_WIDTH  destination being claimed.
- busy_count  output  $clog2(NUM_REGS+1)  number of registers currently busy.

Behaviour:
- Reset (async, rst_n=0):
  - All registers clear to 0.
  - All busy bits clear; busy_count=0.
  - read_data follows cleared storage, so it reads 0; read_busy=0.
- Writes, registered at rising clk:
  - register[a] <= data for every port with write_enable=1.
  - Multiple write ports hitting the same address in one cycle: the highest-indexed port wins.
- Reads, combinational, zero latency:
  - Default: read_data = register[read_addr].
  - Bypass: if any write port is enabled to the same address in the same cycle, read_data = that port's write_data (highest index wins).
  - Read address >= NUM_REGS (non-power-of-2 depth): read_data=0, read_busy=0.
- Scoreboard, busy[NUM_REGS], updated at rising clk:
  - Set: claim_valid=1 sets busy[claim_addr].
  - Clear: an enabled write to address a clears busy[a].
  - Same address claimed and written in the same cycle: claim wins, busy stays/becomes 1 (a newer producer is in flight).
  - Claim of an already-busy register: busy stays 1, no error.
  - Write to a non-busy register: the data is written, busy stays 0.
- read_busy[r] = busy[read_addr_r] AND NOT (same-cycle enabled write to that address). A read serviced by bypass is therefore not busy.
- busy_count:
  - Registered; always equals popcount of the busy vector after each edge.
  - Maintained incrementally (+set −clear per cycle); must never wrap.
  - Maximum value is NUM_REGS, or NUM_REGS−1 when grounded.
- REG_ZERO_GROUND=1:
  - Writes to address 0 are dropped and give no bypass; reads of address 0 return 0.
  - Claims of address 0 are ignored; read_busy for address 0 is always 0.
- Reset mid-operation: asynchronous assertion immediately clears storage and scoreboard; pending claims are lost. First valid operation is on the first rising edge after deassertion.

Optional Feature:
- Macro REGFILE_BYPASS_EN.
- Defined: write-to-read bypass as above; read_busy masks same-cycle writes.
- Undefined:
  - read_data = stored register value only; a same-cycle write becomes visible the next cycle.
  - read_busy = busy[read_addr] unmasked.
  - Scoreboard and busy_count are unchanged.

Test Plan:
1. Reset, then read all addresses on every port -> read_data=0, read_busy=0, busy_count=0; write 0xDEADBEEF to reg 0 (grounded) -> reg 0 still reads 0.
2. Claim reg 5, next cycle read reg 5 -> read_busy=1, busy_count=1. Write 0x1234 to reg 5 with read of reg 5 in the same cycle:
   - bypass build: read_data=0x1234, read_busy=0.
   - no-bypass build: read_data=old value, read_busy=1.
   - Either build: next cycle read_busy=0, busy_count=0.
3. NUM_WRITE_PORTS=2, both ports write reg 7 (port0=0xAAAA, port1=0x5555) -> reg 7 reads 0x5555 afterwards.
4. Claim reg 9 while writing reg 9 in the same cycle -> busy[9]=1, busy_count unchanged if already busy, +1 otherwise. Claim reg 3 while writing reg 4 (busy) in the same cycle -> busy_count net 0.
5. Claim regs 1..31 on consecutive cycles -> busy_count reaches 31. Assert rst_n=0 asynchronously mid-sequence -> busy_count=0 and all read_busy=0 before the next clk edge.
